// File: rtl/touch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : touch_pkg
// Description : Shared types and constants for the resistive-touch ADC reader.
// Revision    : 1.0 - initial release
// ============================================================================
package touch_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        XFER_X = 3'd1,
        GAP    = 3'd2,
        XFER_Y = 3'd3,
        UPDATE = 3'd4,
        HOLD   = 3'd5
    } touch_state_t;

    localparam logic [7:0] CMD_X      = 8'h92;
    localparam logic [7:0] CMD_Y      = 8'hD2;
    localparam int         XFER_BITS  = 24;
    localparam int         DATA_FIRST = 10;
    localparam int         DATA_LAST  = 21;
    localparam int         DATA_W     = 12;

    // rise_idx is the 0-based DCLK rising-edge number within a transfer
    function automatic logic is_data_edge(input logic [4:0] rise_idx);
        return (rise_idx >= 5'(DATA_FIRST - 1)) && (rise_idx <= 5'(DATA_LAST - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/touch_spi_xfer.sv
`default_nettype none
// ============================================================================
// Module      : touch_spi_xfer
// Description : One 24-DCLK command/response frame to the touch ADC.
// Revision    : 1.0 - initial release
// ============================================================================
module touch_spi_xfer
    import touch_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [7:0]        i_cmd,
    input  logic              i_dout,
    output logic              o_done,
    output logic [DATA_W-1:0] o_data,
    output logic              o_dclk,
    output logic              o_din,
    output logic              o_cs_n
);

    localparam int c_DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_HALF_W = $clog2(2 * XFER_BITS);

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_HALF_W-1:0] c_HALF_LAST = c_HALF_W'(2 * XFER_BITS - 1);

    logic                r_run;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_HALF_W-1:0] r_half;
    logic                r_dclk;
    logic                r_din;
    logic                r_cs_n;
    logic [7:0]          r_cmd_sr;
    logic [DATA_W-1:0]   r_data_sr;

    logic w_tick;
    logic w_last;
    logic w_sample;

    assign w_tick   = r_run && (r_div == c_DIV_LAST);
    assign w_last   = w_tick && (r_half == c_HALF_LAST);
    assign w_sample = is_data_edge(r_half[c_HALF_W-1:1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run     <= 1'b0;
            r_div     <= '0;
            r_half    <= '0;
            r_dclk    <= 1'b0;
            r_din     <= 1'b0;
            r_cs_n    <= 1'b1;
            r_cmd_sr  <= '0;
            r_data_sr <= '0;
        end else if (i_start && !r_run) begin
            r_run     <= 1'b1;
            r_div     <= '0;
            r_half    <= '0;
            r_dclk    <= 1'b0;
            r_cs_n    <= 1'b0;
            r_din     <= i_cmd[7];
            r_cmd_sr  <= {i_cmd[6:0], 1'b0};
            r_data_sr <= '0;
        end else if (r_run) begin
            if (w_tick) begin
                r_div <= '0;
                if (w_last) begin
                    // 24th falling edge: close the frame instead of toggling
                    r_run  <= 1'b0;
                    r_half <= '0;
                    r_dclk <= 1'b0;
                    r_din  <= 1'b0;
                    r_cs_n <= 1'b1;
                end else begin
                    r_half <= r_half + 1'b1;
                    r_dclk <= ~r_dclk;
                    if (!r_dclk) begin
                        if (w_sample) begin
                            r_data_sr <= {r_data_sr[DATA_W-2:0], i_dout};
                        end
                    end else begin
                        // zeros shift in behind the command, so DIN idles low after bit 8
                        r_din    <= r_cmd_sr[7];
                        r_cmd_sr <= {r_cmd_sr[6:0], 1'b0};
                    end
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_done = w_last;
    assign o_data = r_data_sr;
    assign o_dclk = r_dclk;
    assign o_din  = r_din;
    assign o_cs_n = r_cs_n;

endmodule
`default_nettype wire

// File: rtl/adc_touch_reader.sv
`default_nettype none
// ============================================================================
// Module      : adc_touch_reader
// Description : Reads an X/Y pair from the touch ADC while the pen is down.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_touch_reader
    import touch_pkg::*;
#(
    parameter int CLK_DIV = 25,
    parameter int HOLDOFF = 50000
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              ADC_PENIRQ_n,
    input  logic              ADC_DOUT,
    output logic              ADC_DCLK,
    output logic              ADC_DIN,
    output logic              ADC_CS_n,
    output logic [DATA_W-1:0] X_COORD,
    output logic [DATA_W-1:0] Y_COORD,
    output logic              NEW_COORD
);

    localparam int c_WAIT_MAX = (HOLDOFF > CLK_DIV) ? HOLDOFF : CLK_DIV;
    localparam int c_WAIT_W   = $clog2(c_WAIT_MAX + 1);

    localparam logic [c_WAIT_W-1:0] c_GAP_LAST  = c_WAIT_W'(CLK_DIV - 1);
    localparam logic [c_WAIT_W-1:0] c_HOLD_LAST = c_WAIT_W'(HOLDOFF - 1);

    logic                r_pen_meta;
    logic                r_pen_sync;
    touch_state_t        r_state;
    logic [c_WAIT_W-1:0] r_wait;
    logic [DATA_W-1:0]   r_x_cap;
    logic [DATA_W-1:0]   r_x_coord;
    logic [DATA_W-1:0]   r_y_coord;
    logic                r_new_coord;

    logic              w_start;
    logic [7:0]        w_cmd;
    logic              w_done;
    logic [DATA_W-1:0] w_data;

    // Pen-down flag is asynchronous to CLK; resets to "pen up"
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_pen_meta <= 1'b1;
            r_pen_sync <= 1'b1;
        end else begin
            r_pen_meta <= ADC_PENIRQ_n;
            r_pen_sync <= r_pen_meta;
        end
    end

    // The engine starts on the same edge the FSM enters a transfer state
    assign w_start = ((r_state == IDLE) && !r_pen_sync) ||
                     ((r_state == GAP) && (r_wait == c_GAP_LAST));
    assign w_cmd   = (r_state == GAP) ? CMD_Y : CMD_X;

    touch_spi_xfer #(
        .CLK_DIV (CLK_DIV)
    ) u_xfer (
        .clk     (CLK),
        .rst_n   (RST_n),
        .i_start (w_start),
        .i_cmd   (w_cmd),
        .i_dout  (ADC_DOUT),
        .o_done  (w_done),
        .o_data  (w_data),
        .o_dclk  (ADC_DCLK),
        .o_din   (ADC_DIN),
        .o_cs_n  (ADC_CS_n)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= IDLE;
            r_wait      <= '0;
            r_x_cap     <= '0;
            r_x_coord   <= '0;
            r_y_coord   <= '0;
            r_new_coord <= 1'b0;
        end else begin
            r_new_coord <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!r_pen_sync) begin
                        r_state <= XFER_X;
                    end
                end
                XFER_X: begin
                    if (w_done) begin
                        r_x_cap <= w_data;
                        r_wait  <= '0;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (r_wait == c_GAP_LAST) begin
                        r_wait  <= '0;
                        r_state <= XFER_Y;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                XFER_Y: begin
                    // Both coordinates change together so no half-updated pair is ever visible
                    if (w_done) begin
                        r_x_coord   <= r_x_cap;
                        r_y_coord   <= w_data;
                        r_new_coord <= 1'b1;
                        r_state     <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_wait  <= '0;
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (r_wait == c_HOLD_LAST) begin
                        r_wait  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: begin
                    r_wait  <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign X_COORD   = r_x_coord;
    assign Y_COORD   = r_y_coord;
    assign NEW_COORD = r_new_coord;

endmodule
`default_nettype wire

// File: tb/tb_adc_touch_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_touch_reader
// Description : Bench for adc_touch_reader with a bus-functional touch ADC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_touch_reader;

    localparam int CLK_DIV   = 2;
    localparam int HOLDOFF   = 20;
    localparam int XFER_CLKS = 24 * 2 * CLK_DIV;
    localparam int PAIR_GAP  = 2 * XFER_CLKS + CLK_DIV + 1 + HOLDOFF + 1;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
    } pair_t;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b1;
    logic        ADC_PENIRQ_n = 1'b1;
    logic        adc_dout = 1'b0;
    logic        ADC_DCLK;
    logic        ADC_DIN;
    logic        ADC_CS_n;
    logic [11:0] X_COORD;
    logic [11:0] Y_COORD;
    logic        NEW_COORD;

    int n_cmp = 0;
    int n_err = 0;
    int rd_idx = 0;
    pair_t exp_q[$];

    adc_touch_reader #(
        .CLK_DIV (CLK_DIV),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .ADC_PENIRQ_n (ADC_PENIRQ_n),
        .ADC_DOUT     (adc_dout),
        .ADC_DCLK     (ADC_DCLK),
        .ADC_DIN      (ADC_DIN),
        .ADC_CS_n     (ADC_CS_n),
        .X_COORD      (X_COORD),
        .Y_COORD      (Y_COORD),
        .NEW_COORD    (NEW_COORD)
    );

    always #5 CLK = ~CLK;

    // ---------------- touch ADC model ----------------
    logic [11:0] mdl_x = '0;
    logic [11:0] mdl_y = '0;
    logic        prev_cs = 1'b1;
    logic        prev_dclk = 1'b0;
    bit          in_win = 1'b0;
    int          mdl_rise = 0;
    int          mdl_fall = 0;
    logic [7:0]  mdl_cmd = '0;
    logic [11:0] mdl_val;
    int          mdl_r;
    int          mdl_per;
    time         last_rise_t = 0;
    int          win_min = 0;
    int          win_max = 0;
    int          cmd_log[$];
    int          rise_log[$];
    int          pmin_log[$];
    int          pmax_log[$];

    always @(ADC_CS_n or ADC_DCLK) begin
        if (ADC_CS_n !== prev_cs) begin
            if (ADC_CS_n === 1'b0) begin
                in_win   = 1'b1;
                mdl_rise = 0;
                mdl_fall = 0;
                mdl_cmd  = '0;
                adc_dout = 1'b0;
                win_min  = 1000000;
                win_max  = 0;
            end else if (in_win) begin
                in_win = 1'b0;
                rise_log.push_back(mdl_rise);
                pmin_log.push_back(win_min);
                pmax_log.push_back(win_max);
                adc_dout = 1'b0;
            end
        end
        if (ADC_DCLK !== prev_dclk && in_win && ADC_CS_n === 1'b0) begin
            if (ADC_DCLK === 1'b1) begin
                mdl_rise++;
                if (mdl_rise > 1) begin
                    mdl_per = int'(($time - last_rise_t) / 10);
                    if (mdl_per < win_min) win_min = mdl_per;
                    if (mdl_per > win_max) win_max = mdl_per;
                end
                last_rise_t = $time;
                if (mdl_rise <= 8) begin
                    mdl_cmd = {mdl_cmd[6:0], ADC_DIN};
                    if (mdl_rise == 8) cmd_log.push_back(int'(mdl_cmd));
                end
            end else begin
                mdl_fall++;
                mdl_r   = mdl_fall + 1;
                mdl_val = (mdl_cmd == 8'hD2) ? mdl_y : mdl_x;
                if (mdl_r >= 10 && mdl_r <= 21) adc_dout = mdl_val[21 - mdl_r];
                else adc_dout = 1'b0;
            end
        end
        prev_cs   = ADC_CS_n;
        prev_dclk = ADC_DCLK;
    end

    // ---------------- output monitor ----------------
    int          cyc = 0;
    int          nc_count = 0;
    logic [11:0] obs_x[64];
    logic [11:0] obs_y[64];
    int          obs_t[64];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (NEW_COORD === 1'b1) begin
            if (nc_count < 64) begin
                obs_x[nc_count] = X_COORD;
                obs_y[nc_count] = Y_COORD;
                obs_t[nc_count] = cyc;
            end
            nc_count++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_touch(input logic [11:0] x, input logic [11:0] y);
        pair_t p;
        mdl_x = x;
        mdl_y = y;
        p.x = x;
        p.y = y;
        exp_q.push_back(p);
    endtask

    task automatic wait_new(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            #1;
            if (nc_count > rd_idx) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        ADC_PENIRQ_n = 1'b1;
        repeat (3) @(negedge CLK);
        #2 RST_n = 1'b0;
        #1;
        n_cmp++; if (ADC_CS_n !== 1'b1) begin n_err++; $display("FAIL reset_cs_n: got %b want 1", ADC_CS_n); end
        n_cmp++; if (ADC_DCLK !== 1'b0) begin n_err++; $display("FAIL reset_dclk: got %b want 0", ADC_DCLK); end
        n_cmp++; if (ADC_DIN !== 1'b0) begin n_err++; $display("FAIL reset_din: got %b want 0", ADC_DIN); end
        n_cmp++; if (X_COORD !== 12'h000) begin n_err++; $display("FAIL reset_x: got %h want 000", X_COORD); end
        n_cmp++; if (Y_COORD !== 12'h000) begin n_err++; $display("FAIL reset_y: got %h want 000", Y_COORD); end
        n_cmp++; if (NEW_COORD !== 1'b0) begin n_err++; $display("FAIL reset_new: got %b want 0", NEW_COORD); end
        repeat (3) @(negedge CLK);
        RST_n = 1'b1;
        repeat (10) @(negedge CLK);
        #1;
        n_cmp++; if (ADC_CS_n !== 1'b1) begin n_err++; $display("FAIL idle_pen_up_cs_n: got %b want 1", ADC_CS_n); end
    endtask

    task automatic test_single_touch;
        pair_t e;
        bit    ok;
        int    c0;
        int    w0;
        c0 = cmd_log.size();
        w0 = rise_log.size();
        set_touch(12'hABC, 12'h123);
        ADC_PENIRQ_n = 1'b0;
        wait_new(600, ok);
        ADC_PENIRQ_n = 1'b1;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL single_timeout: got no NEW_COORD want pulse"); return; end
        e = exp_q.pop_front();
        n_cmp++; if (obs_x[rd_idx] !== e.x) begin n_err++; $display("FAIL single_x: got %h want %h", obs_x[rd_idx], e.x); end
        n_cmp++; if (obs_y[rd_idx] !== e.y) begin n_err++; $display("FAIL single_y: got %h want %h", obs_y[rd_idx], e.y); end
        rd_idx++;
        repeat (60) @(negedge CLK);
        #1;
        n_cmp++; if (nc_count !== rd_idx) begin n_err++; $display("FAIL single_pulse_count: got %0d want %0d", nc_count, rd_idx); end
        n_cmp++;
        if (cmd_log.size() - c0 !== 2) begin
            n_err++; $display("FAIL single_cmd_count: got %0d want 2", cmd_log.size() - c0);
        end else begin
            n_cmp++; if (cmd_log[c0] !== 32'h92) begin n_err++; $display("FAIL single_cmd_x: got %h want 92", cmd_log[c0]); end
            n_cmp++; if (cmd_log[c0+1] !== 32'hD2) begin n_err++; $display("FAIL single_cmd_y: got %h want d2", cmd_log[c0+1]); end
        end
        n_cmp++;
        if (rise_log.size() - w0 !== 2) begin
            n_err++; $display("FAIL single_window_count: got %0d want 2", rise_log.size() - w0);
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++; if (rise_log[w0+k] !== 24) begin n_err++; $display("FAIL single_dclk_periods%0d: got %0d want 24", k, rise_log[w0+k]); end
                n_cmp++; if (pmin_log[w0+k] !== 2 * CLK_DIV) begin n_err++; $display("FAIL single_dclk_min%0d: got %0d want %0d", k, pmin_log[w0+k], 2 * CLK_DIV); end
                n_cmp++; if (pmax_log[w0+k] !== 2 * CLK_DIV) begin n_err++; $display("FAIL single_dclk_max%0d: got %0d want %0d", k, pmax_log[w0+k], 2 * CLK_DIV); end
            end
        end
    endtask

    task automatic test_extremes;
        logic [11:0] xs[2];
        logic [11:0] ys[2];
        pair_t       e;
        bit          ok;
        xs[0] = 12'h000; ys[0] = 12'hFFF;
        xs[1] = 12'hFFF; ys[1] = 12'h000;
        for (int k = 0; k < 2; k++) begin
            set_touch(xs[k], ys[k]);
            ADC_PENIRQ_n = 1'b0;
            wait_new(600, ok);
            ADC_PENIRQ_n = 1'b1;
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL extreme%0d_timeout: got no NEW_COORD want pulse", k); return; end
            e = exp_q.pop_front();
            n_cmp++; if (obs_x[rd_idx] !== e.x) begin n_err++; $display("FAIL extreme%0d_x: got %h want %h", k, obs_x[rd_idx], e.x); end
            n_cmp++; if (obs_y[rd_idx] !== e.y) begin n_err++; $display("FAIL extreme%0d_y: got %h want %h", k, obs_y[rd_idx], e.y); end
            rd_idx++;
            repeat (40) @(negedge CLK);
        end
    endtask

    task automatic test_held_touch;
        pair_t e;
        bit    ok;
        int    t0;
        int    lows;
        t0 = rd_idx;
        for (int k = 0; k < 3; k++) set_touch(12'h5A5, 12'hA5A);
        ADC_PENIRQ_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_new(600, ok);
            if (k == 2) ADC_PENIRQ_n = 1'b1;
            n_cmp++;
            if (!ok) begin n_err++; ADC_PENIRQ_n = 1'b1; $display("FAIL held%0d_timeout: got no NEW_COORD want pulse", k); return; end
            e = exp_q.pop_front();
            n_cmp++; if (obs_x[rd_idx] !== e.x) begin n_err++; $display("FAIL held%0d_x: got %h want %h", k, obs_x[rd_idx], e.x); end
            n_cmp++; if (obs_y[rd_idx] !== e.y) begin n_err++; $display("FAIL held%0d_y: got %h want %h", k, obs_y[rd_idx], e.y); end
            rd_idx++;
            if (k == 0) begin
                lows = 0;
                repeat (HOLDOFF) begin
                    @(negedge CLK);
                    if (ADC_CS_n !== 1'b1) lows++;
                end
                n_cmp++; if (lows !== 0) begin n_err++; $display("FAIL held_cs_in_hold: got %0d low clocks want 0", lows); end
            end
        end
        n_cmp++; if (obs_t[t0+1] - obs_t[t0] !== PAIR_GAP) begin n_err++; $display("FAIL held_spacing1: got %0d want %0d", obs_t[t0+1] - obs_t[t0], PAIR_GAP); end
        n_cmp++; if (obs_t[t0+2] - obs_t[t0+1] !== PAIR_GAP) begin n_err++; $display("FAIL held_spacing2: got %0d want %0d", obs_t[t0+2] - obs_t[t0+1], PAIR_GAP); end
        repeat (300) @(negedge CLK);
        #1;
        n_cmp++; if (nc_count !== rd_idx) begin n_err++; $display("FAIL held_after_release: got %0d pulses want %0d", nc_count, rd_idx); end
    endtask

    task automatic test_release_mid;
        pair_t e;
        bit    ok;
        bit    hit;
        int    c0;
        int    w1;
        c0 = cmd_log.size();
        set_touch(12'h3C7, 12'h81E);
        ADC_PENIRQ_n = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (in_win && mdl_rise >= 5) begin hit = 1'b1; break; end
        end
        ADC_PENIRQ_n = 1'b1;
        n_cmp++;
        if (!hit) begin n_err++; $display("FAIL release_no_transfer: got idle want X transfer"); return; end
        wait_new(600, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL release_timeout: got no NEW_COORD want pulse"); return; end
        e = exp_q.pop_front();
        n_cmp++; if (obs_x[rd_idx] !== e.x) begin n_err++; $display("FAIL release_x: got %h want %h", obs_x[rd_idx], e.x); end
        n_cmp++; if (obs_y[rd_idx] !== e.y) begin n_err++; $display("FAIL release_y: got %h want %h", obs_y[rd_idx], e.y); end
        rd_idx++;
        n_cmp++; if (cmd_log.size() - c0 !== 2) begin n_err++; $display("FAIL release_cmds: got %0d want 2", cmd_log.size() - c0); end
        w1 = rise_log.size();
        repeat (300) @(negedge CLK);
        #1;
        n_cmp++; if (nc_count !== rd_idx) begin n_err++; $display("FAIL release_extra_pulse: got %0d want %0d", nc_count, rd_idx); end
        n_cmp++; if (rise_log.size() !== w1) begin n_err++; $display("FAIL release_extra_xfer: got %0d windows want %0d", rise_log.size(), w1); end
        n_cmp++; if (ADC_CS_n !== 1'b1) begin n_err++; $display("FAIL release_cs_idle: got %b want 1", ADC_CS_n); end
    endtask

    task automatic test_reset_mid;
        pair_t e;
        bit    ok;
        bit    hit;
        int    c0;
        int    rel_cyc;
        c0 = cmd_log.size();
        mdl_x = 12'h7E1;
        mdl_y = 12'h2B4;
        ADC_PENIRQ_n = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if (cmd_log.size() >= c0 + 2 && in_win && mdl_rise >= 15) begin hit = 1'b1; break; end
        end
        n_cmp++;
        if (!hit) begin n_err++; ADC_PENIRQ_n = 1'b1; $display("FAIL rstmid_no_y_transfer: got none want Y transfer"); return; end
        #3 RST_n = 1'b0;
        #1;
        n_cmp++; if (ADC_CS_n !== 1'b1) begin n_err++; $display("FAIL rstmid_cs_n: got %b want 1", ADC_CS_n); end
        n_cmp++; if (X_COORD !== 12'h000) begin n_err++; $display("FAIL rstmid_x: got %h want 000", X_COORD); end
        n_cmp++; if (Y_COORD !== 12'h000) begin n_err++; $display("FAIL rstmid_y: got %h want 000", Y_COORD); end
        n_cmp++; if (nc_count !== rd_idx) begin n_err++; $display("FAIL rstmid_partial_pulse: got %0d want %0d", nc_count, rd_idx); end
        repeat (3) @(negedge CLK);
        RST_n = 1'b1;
        rel_cyc = cyc;
        set_touch(12'h7E1, 12'h2B4);
        wait_new(600, ok);
        ADC_PENIRQ_n = 1'b1;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rstmid_timeout: got no NEW_COORD want pulse"); return; end
        e = exp_q.pop_front();
        n_cmp++; if (obs_t[rd_idx] - rel_cyc !== 3 + 2 * XFER_CLKS + CLK_DIV) begin n_err++; $display("FAIL rstmid_latency: got %0d want %0d", obs_t[rd_idx] - rel_cyc, 3 + 2 * XFER_CLKS + CLK_DIV); end
        n_cmp++; if (obs_x[rd_idx] !== e.x) begin n_err++; $display("FAIL rstmid_x_after: got %h want %h", obs_x[rd_idx], e.x); end
        n_cmp++; if (obs_y[rd_idx] !== e.y) begin n_err++; $display("FAIL rstmid_y_after: got %h want %h", obs_y[rd_idx], e.y); end
        rd_idx++;
        repeat (60) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_single_touch();
        test_extremes();
        test_held_touch();
        test_release_mid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
